// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: packs MSB-first bytes into 32-bit instructions and
// writes them to consecutive instruction-memory words until HALT or memory full.
module instr_mem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_word_count
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    state_t              state_q;
    logic [1:0]          byte_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         word_q;
    logic [31:0]         word_d;
    logic                byte_ready_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [31:0]         wr_data_q;
    logic                busy_q;
    logic                done_q;
    logic                overflow_q;
    logic [ADDR_W:0]     word_count_q;

    assign word_d = {word_q[23:0], i_byte};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A start wins over any byte offered in the same cycle.
                    if (i_start) begin
                        state_q      <= LOAD;
                        byte_cnt_q   <= '0;
                        addr_q       <= '0;
                        word_q       <= '0;
                        wr_addr_q    <= '0;
                        word_count_q <= '0;
                        done_q       <= 1'b0;
                        overflow_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (i_byte_valid && byte_ready_q) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= WRITE;
                            byte_ready_q <= 1'b0;
                            wr_en_q      <= 1'b1;
                            wr_addr_q    <= addr_q;
                            wr_data_q    <= word_d;
                        end
                    end
                end
                WRITE: begin
                    wr_en_q      <= 1'b0;
                    word_count_q <= word_count_q + CNT_ONE;
                    if (word_q == HALT_WORD) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        overflow_q <= 1'b0;
                    end else if (addr_q == ADDR_LAST) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        overflow_q <= 1'b1;
                    end else begin
                        state_q      <= LOAD;
                        addr_q       <= addr_q + ADDR_ONE;
                        byte_cnt_q   <= '0;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_byte_ready = byte_ready_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_overflow   = overflow_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a cycle table for the HALT flow plus
// hand-written sequences; a second instance with ADDR_W=2 covers memory-full.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bvalid = 1'b0;
    logic [7:0]  bdata = 8'h00;

    logic        rdy, wen, busy, done, ovf;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [8:0]  cnt;

    logic        rdy_s, wen_s, busy_s, done_s, ovf_s;
    logic [1:0]  waddr_s;
    logic [31:0] wdata_s;
    logic [2:0]  cnt_s;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];
    wr_t wqs[$];

    typedef struct {
        logic        s, v;
        logic [7:0]  b;
        logic        rdy, wen;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        busy, done, ovf;
        logic [8:0]  cnt;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_byte_valid(bvalid),
        .i_byte(bdata), .o_byte_ready(rdy), .o_wr_en(wen), .o_wr_addr(waddr),
        .o_wr_data(wdata), .o_busy(busy), .o_done(done), .o_overflow(ovf),
        .o_word_count(cnt)
    );

    instr_mem_loader #(.ADDR_W(2)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_byte_valid(bvalid),
        .i_byte(bdata), .o_byte_ready(rdy_s), .o_wr_en(wen_s), .o_wr_addr(waddr_s),
        .o_wr_data(wdata_s), .o_busy(busy_s), .o_done(done_s), .o_overflow(ovf_s),
        .o_word_count(cnt_s)
    );

    // Record every memory write mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (wen === 1'b1) wq.push_back({waddr, wdata});
        if (wen_s === 1'b1) wqs.push_back({6'd0, waddr_s, wdata_s});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] b);
        start  = s;
        bvalid = v;
        bdata  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] b,
                                input logic r, input logic we, input logic [7:0] a,
                                input logic [31:0] d, input logic bu, input logic dn,
                                input logic ov, input logic [8:0] c);
        vec_t t;
        t.s = s; t.v = v; t.b = b; t.rdy = r; t.wen = we; t.addr = a; t.data = d;
        t.busy = bu; t.done = dn; t.ovf = ov; t.cnt = c;
        return t;
    endfunction

    initial begin
        // HALT flow; row 0 also offers a byte alongside start, which must be dropped.
        tbl[0]  = mk(1, 1, 8'hAA, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd0);
        tbl[1]  = mk(0, 1, 8'h20, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd0);
        tbl[2]  = mk(0, 1, 8'h01, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd0);
        tbl[3]  = mk(0, 1, 8'h00, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd0);
        tbl[4]  = mk(0, 1, 8'h05, 0, 1, 8'd0, 32'h20010005, 1, 0, 0, 9'd0);
        tbl[5]  = mk(0, 0, 8'h00, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd1);
        tbl[6]  = mk(0, 1, 8'hFF, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd1);
        tbl[7]  = mk(0, 1, 8'hFF, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd1);
        tbl[8]  = mk(0, 1, 8'hFF, 1, 0, 8'd0, 32'h0,        1, 0, 0, 9'd1);
        tbl[9]  = mk(0, 1, 8'hFF, 0, 1, 8'd1, 32'hFFFFFFFF, 1, 0, 0, 9'd1);
        tbl[10] = mk(0, 0, 8'h00, 0, 0, 8'd1, 32'h0,        0, 1, 0, 9'd2);
        tbl[11] = mk(0, 1, 8'hFF, 0, 0, 8'd1, 32'h0,        0, 1, 0, 9'd2);

        // Reset state
        do_reset();
        chk("rst_ready", {31'd0, rdy}, 32'd0);
        chk("rst_wr_en", {31'd0, wen}, 32'd0);
        chk("rst_addr", {24'd0, waddr}, 32'd0);
        chk("rst_data", wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_count", {23'd0, cnt}, 32'd0);
        idle();
        chk("idle_ignores_bytes", {31'd0, rdy}, 32'd0);

        // HALT flow, cycle by cycle
        wq.delete();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].b);
            chk($sformatf("t%0d_ready", i), {31'd0, rdy}, {31'd0, tbl[i].rdy});
            chk($sformatf("t%0d_wr_en", i), {31'd0, wen}, {31'd0, tbl[i].wen});
            chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("t%0d_done", i), {31'd0, done}, {31'd0, tbl[i].done});
            chk($sformatf("t%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ovf});
            chk($sformatf("t%0d_count", i), {23'd0, cnt}, {23'd0, tbl[i].cnt});
            if (tbl[i].wen || tbl[i].done)
                chk($sformatf("t%0d_addr", i), {24'd0, waddr}, {24'd0, tbl[i].addr});
            if (tbl[i].wen)
                chk($sformatf("t%0d_data", i), wdata, tbl[i].data);
        end
        chk("halt_nwrites", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("halt_w0", {wq[0].addr, wq[0].data}, {8'd0, 32'h20010005});
            chk("halt_w1", {wq[1].addr, wq[1].data}, {8'd1, 32'hFFFFFFFF});
            chk("dec_opcode", {26'd0, wq[0].data[31:26]}, 32'h08);
            chk("dec_rs", {27'd0, wq[0].data[25:21]}, 32'd0);
            chk("dec_rt", {27'd0, wq[0].data[20:16]}, 32'd1);
            chk("dec_imm", {16'd0, wq[0].data[15:0]}, 32'h0005);
        end

        // Gapped stream: 3 idle cycles between bytes
        do_reset();
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        begin
            logic [7:0] gb [4];
            gb[0] = 8'h00; gb[1] = 8'h22; gb[2] = 8'h18; gb[3] = 8'h20;
            for (int k = 0; k < 3; k++) begin
                send(gb[k]);
                chk($sformatf("gap_b%0d_wr_en", k), {31'd0, wen}, 32'd0);
                for (int g = 0; g < 3; g++) begin
                    idle();
                    chk($sformatf("gap_b%0d_i%0d_wr_en", k, g), {31'd0, wen}, 32'd0);
                    chk($sformatf("gap_b%0d_i%0d_ready", k, g), {31'd0, rdy}, 32'd1);
                end
            end
            send(gb[3]);
        end
        chk("gap_wr_en", {31'd0, wen}, 32'd1);
        chk("gap_addr", {24'd0, waddr}, 32'd0);
        chk("gap_data", wdata, 32'h00221820);
        idle();
        chk("gap_wr_pulse_end", {31'd0, wen}, 32'd0);
        chk("gap_nwrites", wq.size(), 1);

        // Overflow on the 4-word instance
        do_reset();
        wqs.delete();
        step(1'b1, 1'b0, 8'h00);
        for (int w = 1; w <= 4; w++) begin
            send(8'h00); send(8'h00); send(8'h00); send(8'(w));
            idle();
        end
        chk("ovf_done", {31'd0, done_s}, 32'd1);
        chk("ovf_flag", {31'd0, ovf_s}, 32'd1);
        chk("ovf_count", {29'd0, cnt_s}, 32'd4);
        chk("ovf_busy", {31'd0, busy_s}, 32'd0);
        chk("ovf_addr_hold", {30'd0, waddr_s}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            send(8'h55);
            chk($sformatf("ovf_ready_%0d", k), {31'd0, rdy_s}, 32'd0);
        end
        idle();
        chk("ovf_nwrites", wqs.size(), 4);
        if (wqs.size() == 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("ovf_w%0d", k), {wqs[k].addr, wqs[k].data},
                    {8'(k), 32'(k + 1)});

        // Restart from DONE after overflow
        wqs.delete();
        step(1'b1, 1'b0, 8'h00);
        chk("rs_done_clr", {31'd0, done_s}, 32'd0);
        chk("rs_ovf_clr", {31'd0, ovf_s}, 32'd0);
        chk("rs_count_clr", {29'd0, cnt_s}, 32'd0);
        chk("rs_ready", {31'd0, rdy_s}, 32'd1);
        chk("rs_busy", {31'd0, busy_s}, 32'd1);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        chk("rs_wr_en", {31'd0, wen_s}, 32'd1);
        chk("rs_addr", {30'd0, waddr_s}, 32'd0);
        chk("rs_data", wdata_s, 32'hFFFFFFFF);
        idle();
        chk("rs_done", {31'd0, done_s}, 32'd1);
        chk("rs_ovf", {31'd0, ovf_s}, 32'd0);
        chk("rs_count", {29'd0, cnt_s}, 32'd1);
        chk("rs_nwrites", wqs.size(), 1);

        // Reset in the middle of a word
        do_reset();
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        send(8'h8C); send(8'h01);
        rst_n = 1'b0;
        idle();
        chk("mr_ready", {31'd0, rdy}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_wr_en", {31'd0, wen}, 32'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        send(8'hAC); send(8'h02); send(8'h00); send(8'h04);
        idle();
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        idle();
        chk("mr_nwrites", wq.size(), 2);
        if (wq.size() >= 1)
            chk("mr_w0", {wq[0].addr, wq[0].data}, {8'd0, 32'hAC020004});
        chk("mr_done", {31'd0, done}, 32'd1);
        chk("mr_count", {23'd0, cnt}, 32'd2);

        // Start during LOAD is ignored
        do_reset();
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle();
        send(8'h12); send(8'h34);
        step(1'b1, 1'b0, 8'h00);
        chk("is_ready", {31'd0, rdy}, 32'd1);
        chk("is_busy", {31'd0, busy}, 32'd1);
        send(8'h56);
        chk("is_no_early_wr", {31'd0, wen}, 32'd0);
        send(8'h78);
        chk("is_wr_en", {31'd0, wen}, 32'd1);
        chk("is_addr", {24'd0, waddr}, 32'd1);
        chk("is_data", wdata, 32'h12345678);
        idle();
        chk("is_count", {23'd0, cnt}, 32'd2);
        chk("is_nwrites", wq.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
